ram_bist: RTL and testbench



---
 rtl/ram_bist.sv | 156 +++++++++++++++
 tb/tb_ram_bist.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/ram_bist.sv
// March-style self-test controller for a small synchronous RAM: write pattern,
// read/compare, write complement, read/compare, then report the result.
module ram_bist #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_seed,
  output logic              o_ram_write_en,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_write_data,
  input  logic [DATA_W-1:0] i_ram_read_data,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_pass,
  output logic [ADDR_W-1:0] o_fail_addr,
  output logic [ADDR_W+1:0] o_fail_count
);

  typedef enum logic [2:0] {IDLE, WR0, RD0, WR1, RD1, DRAIN, DONE} state_t;

  state_t              state;
  logic [DATA_W-1:0]   seed_q;
  logic                drain_q;
  logic                v1, v2;
  logic [DATA_W-1:0]   exp1, exp2;
  logic [ADDR_W-1:0]   a1, a2;
  logic [ADDR_W-1:0]   nxt;
  logic                last;

  assign nxt  = o_ram_addr + ADDR_W'(1);
  assign last = (o_ram_addr == ADDR_W'(DEPTH - 1));

  function automatic logic [DATA_W-1:0] pat(input logic [DATA_W-1:0] s,
                                            input logic [ADDR_W-1:0] a);
    return s + DATA_W'(a);
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state            <= IDLE;
      seed_q           <= '0;
      drain_q          <= 1'b0;
      v1               <= 1'b0;
      v2               <= 1'b0;
      exp1             <= '0;
      exp2             <= '0;
      a1               <= '0;
      a2               <= '0;
      o_ram_write_en   <= 1'b0;
      o_ram_addr       <= '0;
      o_ram_write_data <= '0;
      o_busy           <= 1'b0;
      o_done           <= 1'b0;
      o_pass           <= 1'b0;
      o_fail_addr      <= '0;
      o_fail_count     <= '0;
    end else begin
      // Read issued with the address at edge k is compared at edge k+2.
      v1   <= 1'b0;
      v2   <= v1;
      exp2 <= exp1;
      a2   <= a1;
      if (v2 && (i_ram_read_data != exp2)) begin
        o_fail_count <= o_fail_count + 1'b1;
        if (o_fail_count == '0) o_fail_addr <= a2;
      end

      case (state)
        IDLE, DONE: begin
          if (i_start) begin
            state            <= WR0;
            seed_q           <= i_seed;
            o_done           <= 1'b0;
            o_pass           <= 1'b0;
            o_fail_addr      <= '0;
            o_fail_count     <= '0;
            o_busy           <= 1'b1;
            o_ram_write_en   <= 1'b1;
            o_ram_addr       <= '0;
            o_ram_write_data <= i_seed;
          end
        end
        WR0: begin
          if (last) begin
            state            <= RD0;
            o_ram_write_en   <= 1'b0;
            o_ram_addr       <= '0;
            o_ram_write_data <= '0;
            v1               <= 1'b1;
            exp1             <= pat(seed_q, '0);
            a1               <= '0;
          end else begin
            o_ram_addr       <= nxt;
            o_ram_write_data <= pat(seed_q, nxt);
          end
        end
        RD0: begin
          if (last) begin
            state            <= WR1;
            o_ram_write_en   <= 1'b1;
            o_ram_addr       <= '0;
            o_ram_write_data <= ~pat(seed_q, '0);
          end else begin
            o_ram_addr <= nxt;
            v1         <= 1'b1;
            exp1       <= pat(seed_q, nxt);
            a1         <= nxt;
          end
        end
        WR1: begin
          if (last) begin
            state            <= RD1;
            o_ram_write_en   <= 1'b0;
            o_ram_addr       <= '0;
            o_ram_write_data <= '0;
            v1               <= 1'b1;
            exp1             <= ~pat(seed_q, '0);
            a1               <= '0;
          end else begin
            o_ram_addr       <= nxt;
            o_ram_write_data <= ~pat(seed_q, nxt);
          end
        end
        RD1: begin
          if (last) begin
            state      <= DRAIN;
            o_ram_addr <= '0;
            drain_q    <= 1'b0;
          end else begin
            o_ram_addr <= nxt;
            v1         <= 1'b1;
            exp1       <= ~pat(seed_q, nxt);
            a1         <= nxt;
          end
        end
        DRAIN: begin
          // Two cycles so the final read's compare lands before the verdict.
          if (drain_q) begin
            state  <= DONE;
            o_busy <= 1'b0;
            o_done <= 1'b1;
            o_pass <= (o_fail_count == '0);
          end else begin
            drain_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_bist.sv
// Bench for ram_bist: RAM model with injectable read faults, table of runs,
// plus hand-written ignored-start, mid-test reset and restart sequences.
module tb_ram_bist;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [7:0] seed;
  logic       we;
  logic [2:0] addr;
  logic [7:0] wdata, ram_rd;
  logic       busy, done, pass;
  logic [2:0] fail_addr;
  logic [4:0] fail_count;

  always #5 clk = ~clk;

  ram_bist #(.ADDR_W(3), .DATA_W(8), .DEPTH(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_seed(seed),
    .o_ram_write_en(we), .o_ram_addr(addr), .o_ram_write_data(wdata),
    .i_ram_read_data(ram_rd), .o_busy(busy), .o_done(done), .o_pass(pass),
    .o_fail_addr(fail_addr), .o_fail_count(fail_count)
  );

  // mode 0 clean, 1 mem[5] bit0 stuck-at-0, 2 bit0 inverted on every read,
  // 3 mem[2] and mem[5] bit0 stuck-at-0
  int         mode = 0;
  logic [7:0] mem [8];
  int         nwr = 0;
  logic [2:0] wa [32];
  logic [7:0] wd [32];
  logic [7:0] rd;

  always @(posedge clk) begin
    if (we === 1'b1) begin
      mem[addr] <= wdata;
      if (nwr < 32) begin
        wa[nwr] = addr;
        wd[nwr] = wdata;
      end
      nwr++;
    end else begin
      rd = mem[addr];
      if (mode == 1 && addr == 3'd5) rd[0] = 1'b0;
      if (mode == 3 && (addr == 3'd5 || addr == 3'd2)) rd[0] = 1'b0;
      if (mode == 2) rd[0] = ~rd[0];
      ram_rd <= rd;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic launch(input logic [7:0] s);
    @(negedge clk);
    seed  = s;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    nwr   = 0;
    chk("busy_after_start", {30'd0, busy, done}, 32'h2);
  endtask

  // Counts edges after E0 until o_done; optional start pulse / reset at an edge.
  task automatic wait_done(input int pulse_at, input int rst_at, output int edges);
    edges = 0;
    while (edges < 60) begin
      @(negedge clk);
      start = (edges + 1 == pulse_at);
      if (edges + 1 == pulse_at) seed = 8'h55;
      rst = (edges + 1 == rst_at);
      @(posedge clk);
      #1;
      edges++;
      start = 1'b0;
      rst   = 1'b0;
      if (edges == rst_at) return;
      if (done) return;
    end
  endtask

  task automatic check_writes(input logic [7:0] s);
    logic [7:0] e;
    chk("write_count", nwr, 16);
    for (int i = 0; i < 16 && i < nwr; i++) begin
      e = (i < 8) ? 8'(s + 8'(i)) : ~8'(s + 8'(i - 8));
      chk($sformatf("wr_addr[%0d]", i), {29'd0, wa[i]}, i % 8);
      chk($sformatf("wr_data[%0d]", i), {24'd0, wd[i]}, {24'd0, e});
    end
  endtask

  task automatic check_result(input logic p, input logic [2:0] fa, input logic [4:0] fc,
                              input int edges);
    chk("done_edge", edges, 34);
    chk("busy_at_done", {31'd0, busy}, 0);
    chk("pass", {31'd0, pass}, {31'd0, p});
    chk("fail_addr", {29'd0, fail_addr}, {29'd0, fa});
    chk("fail_count", {27'd0, fail_count}, {27'd0, fc});
  endtask

  typedef struct {
    logic [7:0] seed;
    int         mode;
    logic       pass;
    logic [2:0] fail_addr;
    logic [4:0] fail_count;
    logic [7:0] w2;
    logic [7:0] w15;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int edges;
    vecs[0] = '{8'h00, 0, 1'b1, 3'd0, 5'd0,  8'h02, 8'hF8};
    vecs[1] = '{8'hFE, 0, 1'b1, 3'd0, 5'd0,  8'h00, 8'hFA};
    vecs[2] = '{8'h01, 1, 1'b0, 3'd5, 5'd1,  8'h03, 8'hF7};
    vecs[3] = '{8'h00, 1, 1'b0, 3'd5, 5'd1,  8'h02, 8'hF8};
    vecs[4] = '{8'hFF, 2, 1'b0, 3'd0, 5'd16, 8'h01, 8'hF9};
    vecs[5] = '{8'h00, 3, 1'b0, 3'd5, 5'd2,  8'h02, 8'hF8};

    rst = 1'b1; start = 1'b1; seed = 8'hAA;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {busy, done, pass, fail_addr, fail_count, we, addr, wdata},
        32'd0);
    chk("reset_no_write", nwr, 0);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_after_reset", {31'd0, busy}, 0);

    for (int v = 0; v < 6; v++) begin
      mode = vecs[v].mode;
      launch(vecs[v].seed);
      wait_done(0, 0, edges);
      check_result(vecs[v].pass, vecs[v].fail_addr, vecs[v].fail_count, edges);
      check_writes(vecs[v].seed);
      chk("wr_hand_2", {24'd0, wd[2]}, {24'd0, vecs[v].w2});
      chk("wr_hand_15", {24'd0, wd[15]}, {24'd0, vecs[v].w15});
    end

    // start pulse (with a different seed) at E5 while busy must be ignored
    mode = 0;
    launch(8'h33);
    wait_done(5, 0, edges);
    check_result(1'b1, 3'd0, 5'd0, edges);
    check_writes(8'h33);

    // reset at E10 aborts the run
    launch(8'h44);
    wait_done(0, 10, edges);
    chk("abort_edge", edges, 10);
    chk("abort_outputs", {busy, done, pass, fail_addr, fail_count, we, addr, wdata},
        32'd0);

    mode = 0;
    launch(8'h66);
    wait_done(0, 0, edges);
    check_result(1'b1, 3'd0, 5'd0, edges);
    check_writes(8'h66);

    // restart straight from DONE with a new seed
    launch(8'h90);
    wait_done(0, 0, edges);
    check_result(1'b1, 3'd0, 5'd0, edges);
    check_writes(8'h90);
    chk("done_held", {31'd0, done}, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
